// File: rtl/instr_fetch_pkg.sv
// Types and constants shared by the instruction fetch unit, its FIFO and its bus interface.
`include "isa.v"

package instr_fetch_pkg;

    localparam int XLEN_W    = `XLEN;
    localparam int WADDR_W   = `WORD_ADDRESS;
    localparam int MEM_WORDS = `MEM_SIZE;

    localparam logic [XLEN_W-1:0] NOP_INSTR = `NOP_INSTRUCTION;
    localparam logic [XLEN_W-1:0] PC_STEP   = `PC_STEP;

    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [XLEN_W-1:0] pc;
        logic [XLEN_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instructions are word aligned; the two low byte-address bits carry no meaning.
    function automatic logic [XLEN_W-1:0] align_pc(input logic [XLEN_W-1:0] pc);
        return pc & ~(XLEN_W'(3));
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory, branch redirect and decode.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [WADDR_W-1:0] imem_addr;
    logic [XLEN_W-1:0]  imem_instr;
    logic               redirect_valid;
    logic [XLEN_W-1:0]  redirect_pc;
    logic               fetch_en;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN_W-1:0]  out_instr;
    logic [XLEN_W-1:0]  out_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        input  fetch_en,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        output fetch_en,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with flush; a push into a full FIFO is accepted when a pop
// happens on the same edge. Only the occupancy count is reset.
module fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o,
    output logic             space_o
);

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;
    logic [1:0]       slot;

    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        space_o = (count_q != 2'd2) || do_pop;
        do_push = push_i && space_o;
        slot    = count_q - {1'b0, do_pop};
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            // Popping shifts the second entry to the head before the new write lands.
            if (do_pop) begin
                mem0_d = mem1_q;
            end
            if (do_push) begin
                if (slot == 2'd0) begin
                    mem0_d = data_i;
                end else begin
                    mem1_d = data_i;
                end
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem0_q <= mem0_d;
        mem1_q <= mem1_d;
    end

    assign head_o  = mem0_q;
    assign count_o = count_q;

endmodule

// File: rtl/isa.v
// Shared ISA constants for the fetch path: data width, word-address width,
// instruction memory size in words, the canonical NOP and the sequential PC step.
`ifndef ISA_V
`define ISA_V

`define XLEN             32
`define WORD_ADDRESS     30
`define MEM_SIZE         1024
`define NOP_INSTRUCTION  32'h0000_0013
`define PC_STEP          4

`endif

// File: rtl/instr_fetch.sv
// Instruction fetch unit: byte PC plus a 2-entry {pc, instr} buffer toward decode.
// Optional FETCH_PERF_EN adds fetch and full-stall performance counters.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    logic [XLEN_W-1:0] pc_q, pc_d;
    logic              push;
    logic              pop;
    logic              space;
    logic              valid;
    logic [1:0]        count;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;

    // A redirect wins over everything: it flushes and suppresses both push and pop.
    always_comb begin
        pop            = valid && bus.out_ready && !bus.redirect_valid;
        push           = bus.fetch_en && !bus.redirect_valid && space;
        wr_entry.pc    = pc_q;
        wr_entry.instr = bus.imem_instr;
        pc_d           = pc_q;
        if (bus.redirect_valid) begin
            pc_d = align_pc(bus.redirect_pc);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (bus.redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .head_o  (head),
        .count_o (count),
        .space_o (space)
    );

    // Empty buffer presents a NOP at pc 0, which also covers the reset state.
    assign valid         = (count != 2'd0);
    assign bus.out_valid = valid;
    assign bus.out_instr = valid ? head.instr : NOP_INSTR;
    assign bus.out_pc    = valid ? head.pc    : '0;
    assign bus.imem_addr = pc_q[WADDR_W+1:2];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, push};
        stall_cnt_d = stall_cnt_q + {31'd0, (count == 2'd2) && !bus.out_ready};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: a vector table plus hand-written
// sequences for backpressure, redirect, PC wrap, asynchronous reset and counters.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    instr_fetch_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] pf_fetch;
    logic [31:0] pf_stall;
`endif

    instr_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (pf_fetch),
        .perf_stall_cnt (pf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: NOP beyond the populated range.
    logic [31:0] mem [0:MEM_WORDS-1];
    always_comb begin
        if (bus.imem_addr < 30'(MEM_WORDS)) begin
            bus.imem_instr = mem[bus.imem_addr[$clog2(MEM_WORDS)-1:0]];
        end else begin
            bus.imem_instr = NOP_INSTR;
        end
    end

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] einstr,
                                input logic [31:0] eaddr);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.fetch_en       = fe;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic chk_head(input string name, input logic ev, input logic [31:0] epc,
                            input logic [31:0] einstr);
        chk({name, "_valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
        chk({name, "_pc"}, bus.out_pc, epc);
        chk({name, "_instr"}, bus.out_instr, einstr);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00a0_0113;

        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        #12;
        chk_head("reset", 1'b0, 32'h0, 32'h0000_0013);
        chk("reset_addr", {2'b00, bus.imem_addr}, 32'h0);

        //            fe    rdy   rv    rpc            ev    epc            einstr          eaddr
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0050_0093, 32'h1);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 32'h00a0_0113, 32'h2);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 32'hA000_0002, 32'h3);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h3);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h3);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'hA000_0003, 32'h4);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'hA000_0003, 32'h5);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'hA000_0003, 32'h5);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 32'hA000_0004, 32'h6);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 32'hA000_0005, 32'h6);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h6);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         32'h0,         32'h40);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 32'hA000_0040, 32'h41);

        step();
        reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            step();
            chk($sformatf("row%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("row%0d_addr", i), {2'b00, bus.imem_addr}, tbl[i].eaddr);
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_pc", i), bus.out_pc, tbl[i].epc);
                chk($sformatf("row%0d_instr", i), bus.out_instr, tbl[i].einstr);
            end
        end

        // Backpressure from reset: buffer fills, PC parks at word 2, then drains in order.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk_head($sformatf("bp%0d", c), 1'b1, 32'h0, 32'h0050_0093);
            chk($sformatf("bp%0d_addr", c), {2'b00, bus.imem_addr}, (c == 0) ? 32'h1 : 32'h2);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk_head("drain0", 1'b1, 32'h4, 32'h00a0_0113);
        step();
        chk("drain1_valid", {31'd0, bus.out_valid}, 32'h0);

        // Redirect while full discards both buffered entries.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0043);
        step();
        chk("redir_valid", {31'd0, bus.out_valid}, 32'h0);
        chk("redir_addr", {2'b00, bus.imem_addr}, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        chk_head("redir0", 1'b1, 32'h40, 32'hA000_0010);
        step();
        chk_head("redir1", 1'b1, 32'h44, 32'hA000_0011);

        // PC wrap at the top of the address space; that address is beyond memory.
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr_pre", {2'b00, bus.imem_addr}, 32'h3FFF_FFFF);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        chk_head("wrap0", 1'b1, 32'hFFFF_FFFC, 32'h0000_0013);
        chk("wrap_addr", {2'b00, bus.imem_addr}, 32'h0);
        step();
        chk_head("wrap1", 1'b1, 32'h0, 32'h0050_0093);

        // Asynchronous reset between edges clears the head immediately.
        #2;
        reset = 1'b0;
        #1;
        chk_head("async_rst", 1'b0, 32'h0, 32'h0000_0013);
        chk("async_rst_addr", {2'b00, bus.imem_addr}, 32'h0);
        step();
        reset = 1'b1;

`ifdef FETCH_PERF_EN
        do_reset();
        chk("perf_rst_fetch", pf_fetch, 32'd0);
        chk("perf_rst_stall", pf_stall, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (11) step();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) step();
        chk("perf_fetch", pf_fetch, 32'd12);
        chk("perf_stall", pf_stall, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
